// File: rtl/seq_divider_n_if.sv
// Valid/ready operand and result channels for seq_divider_n.
// master drives operands and accepts results; slave is the divider.
interface seq_divider_n_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_n.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Define DIV_EARLY_EXIT_EN for 1-cycle results on divide-by-zero or dividend < divisor.
module seq_divider_n #(
    parameter int unsigned N = 32
) (
    input logic           clk,
    input logic           rst,
    seq_divider_n_if.slave bus
);
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_next;
    logic [N-1:0]  dq;        // dividend bits shift out as quotient bits shift in
    logic [N-1:0]  dvs;
    logic [N-1:0]  rem;
    logic [CW-1:0] cnt;
    logic          dbz;
    logic          in_ready_r;
    logic          out_valid_r;
`ifdef DIV_EARLY_EXIT_EN
    logic          early;
`endif

    logic [N:0]    trial;
    logic [N-1:0]  diff;
    logic          take;
    logic          last;

    always_comb begin
        trial = {rem, dq[N-1]};
        // Restored result is always below the divisor, so N bits suffice.
        diff  = trial[N-1:0] - dvs;
        take  = trial >= {1'b0, dvs};
        last  = cnt == CW'(N - 1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid) state_next = CALC;
`ifdef DIV_EARLY_EXIT_EN
            CALC: if (early || last) state_next = DONE;
`else
            CALC: if (last) state_next = DONE;
`endif
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            dq          <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            dbz         <= 1'b0;
`ifdef DIV_EARLY_EXIT_EN
            early       <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            in_ready_r  <= state_next == IDLE;
            out_valid_r <= state_next == DONE;
            case (state)
                IDLE: if (bus.in_valid) begin
                    dq    <= bus.dividend;
                    dvs   <= bus.divisor;
                    rem   <= '0;
                    cnt   <= '0;
                    dbz   <= bus.divisor == '0;
`ifdef DIV_EARLY_EXIT_EN
                    early <= (bus.divisor == '0) || (bus.dividend < bus.divisor);
`endif
                end
                CALC: begin
`ifdef DIV_EARLY_EXIT_EN
                    if (early) begin
                        rem <= dq;
                        dq  <= dbz ? '1 : '0;
                    end else
`endif
                    begin
                        rem <= take ? diff : trial[N-1:0];
                        dq  <= {dq[N-2:0], take};
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.quotient    = dq;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider_n.sv
// Self-checking bench for seq_divider_n: directed cases plus random operands
// checked against plain-arithmetic division; latency follows DIV_EARLY_EXIT_EN.
module tb_seq_divider_n;
    localparam int unsigned N = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_n_if #(.N(N)) bus();

    seq_divider_n #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
        return (b == 0) ? {N{1'b1}} : a / b;
    endfunction

    function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_lat(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef DIV_EARLY_EXIT_EN
        if (b == 0 || a < b) return 1;
`endif
        return N;
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
        int guard = 0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("accept_timeout", N'(guard), 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic wait_result(input logic [N-1:0] a, input logic [N-1:0] b);
        int lat = 0;
        check("busy_after_accept", {{(N-1){1'b0}}, bus.in_ready}, 0);
        while (bus.out_valid !== 1'b1 && lat < int'(N) + 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", N'(lat), N'(ref_lat(a, b)));
        check("quotient", bus.quotient, ref_q(a, b));
        check("remainder", bus.remainder, ref_r(a, b));
        check("div_by_zero", {{(N-1){1'b0}}, bus.div_by_zero}, N'(b == 0));
        check("in_ready_in_done", {{(N-1){1'b0}}, bus.in_ready}, 0);
    endtask

    task automatic hold(input int cycles, input logic [N-1:0] a, input logic [N-1:0] b);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("hold_out_valid", {{(N-1){1'b0}}, bus.out_valid}, 1);
            check("hold_in_ready", {{(N-1){1'b0}}, bus.in_ready}, 0);
            check("hold_quotient", bus.quotient, ref_q(a, b));
            check("hold_remainder", bus.remainder, ref_r(a, b));
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("released_out_valid", {{(N-1){1'b0}}, bus.out_valid}, 0);
        check("released_in_ready", {{(N-1){1'b0}}, bus.in_ready}, 1);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall);
        send(a, b);
        wait_result(a, b);
        hold(stall, a, b);
        release_result();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] a, b;
        int seen;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", {{(N-1){1'b0}}, bus.in_ready}, 1);
        check("reset_out_valid", {{(N-1){1'b0}}, bus.out_valid}, 0);
        check("reset_quotient", bus.quotient, 0);
        check("reset_remainder", bus.remainder, 0);
        check("reset_dbz", {{(N-1){1'b0}}, bus.div_by_zero}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(100, 7, 0);
        run_op(32'hFFFF_FFFF, 1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'h1234_5678, 0, 0);
        run_op(5, 9, 0);

        // Back-pressure with a pending request that must wait for the release.
        send(1000, 7);
        wait_result(1000, 7);
        bus.dividend = 81;
        bus.divisor  = 9;
        bus.in_valid = 1'b1;
        hold(10, 1000, 7);
        release_result();
        send(81, 9);
        wait_result(81, 9);
        release_result();

        // Abort mid-calculation.
        send(1000, 3);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", {{(N-1){1'b0}}, bus.in_ready}, 1);
        check("abort_out_valid", {{(N-1){1'b0}}, bus.out_valid}, 0);
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_dbz", {{(N-1){1'b0}}, bus.div_by_zero}, 0);
        seen = 0;
        for (int i = 0; i < int'(N) + 4; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        check("abort_no_result", N'(seen), 0);
        run_op(1000, 3, 0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = (a == {N{1'b1}}) ? a : a + 1;
                default: b = (i % 4 == 3) ? '0 : ($urandom >> $urandom_range(0, 31));
            endcase
            run_op(a, b, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
